// File: rtl/zig_zag_block_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// zig_zag_block_sequencer
//
// Purpose:
//   Sequences 8x8 coefficient blocks through an external 128-entry,
//   two-bank coefficient RAM. Coefficients arrive in row-major order and are
//   written linearly into the current write bank. Once a bank holds a complete
//   block it is read back in JPEG zig-zag order. While one bank is drained,
//   the other bank can be filled (ping-pong).
//
// Ports:
//   clock         in   single clock, rising-edge
//   reset         in   asynchronous, active-high reset
//   in_valid      in   upstream presents a row-major coefficient
//   in_ready      out  a coefficient is accepted this cycle (combinational)
//   wr_en         out  RAM write strobe = in_valid && in_ready
//   wr_addr[6:0]  out  {write bank, row-major index}
//   rd_en         out  RAM read strobe (RAM read port has 1-cycle latency)
//   rd_addr[6:0]  out  {read bank, row-major index of current zig-zag slot}
//   out_valid     out  RAM read data + out_zz_index/out_last valid (registered)
//   out_ready     in   downstream consumes the current output
//   out_zz_index  out  zig-zag position 0..63 of the current output
//   out_last      out  marks zig-zag position 63
//   blocks_full   out  number of banks fully written and not yet fully read
// -----------------------------------------------------------------------------
module zig_zag_block_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       wr_en,
   output logic [6:0] wr_addr,
   output logic       rd_en,
   output logic [6:0] rd_addr,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_zz_index,
   output logic       out_last,
   output logic [1:0] blocks_full
);

   // Zig-zag position -> row-major index, written as 6'o<row><col>.
   function automatic logic [5:0] f_zz_to_rowmajor(input logic [5:0] zz);
      logic [5:0] rm;
      case (zz)
         6'd0:  rm = 6'o00;  6'd1:  rm = 6'o01;  6'd2:  rm = 6'o10;  6'd3:  rm = 6'o20;
         6'd4:  rm = 6'o11;  6'd5:  rm = 6'o02;  6'd6:  rm = 6'o03;  6'd7:  rm = 6'o12;
         6'd8:  rm = 6'o21;  6'd9:  rm = 6'o30;  6'd10: rm = 6'o40;  6'd11: rm = 6'o31;
         6'd12: rm = 6'o22;  6'd13: rm = 6'o13;  6'd14: rm = 6'o04;  6'd15: rm = 6'o05;
         6'd16: rm = 6'o14;  6'd17: rm = 6'o23;  6'd18: rm = 6'o32;  6'd19: rm = 6'o41;
         6'd20: rm = 6'o50;  6'd21: rm = 6'o60;  6'd22: rm = 6'o51;  6'd23: rm = 6'o42;
         6'd24: rm = 6'o33;  6'd25: rm = 6'o24;  6'd26: rm = 6'o15;  6'd27: rm = 6'o06;
         6'd28: rm = 6'o07;  6'd29: rm = 6'o16;  6'd30: rm = 6'o25;  6'd31: rm = 6'o34;
         6'd32: rm = 6'o43;  6'd33: rm = 6'o52;  6'd34: rm = 6'o61;  6'd35: rm = 6'o70;
         6'd36: rm = 6'o71;  6'd37: rm = 6'o62;  6'd38: rm = 6'o53;  6'd39: rm = 6'o44;
         6'd40: rm = 6'o35;  6'd41: rm = 6'o26;  6'd42: rm = 6'o17;  6'd43: rm = 6'o27;
         6'd44: rm = 6'o36;  6'd45: rm = 6'o45;  6'd46: rm = 6'o54;  6'd47: rm = 6'o63;
         6'd48: rm = 6'o72;  6'd49: rm = 6'o73;  6'd50: rm = 6'o64;  6'd51: rm = 6'o55;
         6'd52: rm = 6'o46;  6'd53: rm = 6'o37;  6'd54: rm = 6'o47;  6'd55: rm = 6'o56;
         6'd56: rm = 6'o65;  6'd57: rm = 6'o74;  6'd58: rm = 6'o75;  6'd59: rm = 6'o66;
         6'd60: rm = 6'o57;  6'd61: rm = 6'o67;  6'd62: rm = 6'o76;  6'd63: rm = 6'o77;
         default: rm = 6'o00;
      endcase
      return rm;
   endfunction

   logic [1:0] r_full;          // per-bank: complete block present, unread
   logic       r_wb;            // write bank pointer
   logic       r_rb;            // read bank pointer
   logic [5:0] r_wcnt;          // row-major write index within bank
   logic [5:0] r_rcnt;          // zig-zag read position within bank
   logic       r_out_valid;
   logic [5:0] r_out_zz;
   logic       r_out_last;

   logic       w_wr_fire;
   logic       w_wr_done;
   logic       w_rd_fire;
   logic       w_rd_done;
   logic [1:0] w_full_nxt;

   // Write side: accept while the current write bank is not holding a block.
   assign in_ready  = ~r_full[r_wb];
   assign w_wr_fire = in_valid & in_ready;
   assign w_wr_done = w_wr_fire & (r_wcnt == 6'd63);
   assign wr_en     = w_wr_fire;
   assign wr_addr   = {r_wb, r_wcnt};

   // Read side: issue a RAM read whenever the output slot is free or is
   // being vacated this cycle, so a held-high out_ready gives full rate.
   assign w_rd_fire = r_full[r_rb] & (~r_out_valid | out_ready);
   assign w_rd_done = w_rd_fire & (r_rcnt == 6'd63);
   assign rd_en     = w_rd_fire;
   assign rd_addr   = {r_rb, f_zz_to_rowmajor(r_rcnt)};

   assign out_valid    = r_out_valid;
   assign out_zz_index = r_out_zz;
   assign out_last     = r_out_last;
   assign blocks_full  = {1'b0, r_full[0]} + {1'b0, r_full[1]};

   // Write completion and read completion can land on the same edge; they
   // always target different banks because a bank is written only while
   // empty and read only while full.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wr_done) begin
         w_full_nxt[r_wb] = 1'b1;
      end
      if (w_rd_done) begin
         w_full_nxt[r_rb] = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_full      <= 2'b00;
         r_wb        <= 1'b0;
         r_rb        <= 1'b0;
         r_wcnt      <= 6'd0;
         r_rcnt      <= 6'd0;
         r_out_valid <= 1'b0;
         r_out_zz    <= 6'd0;
         r_out_last  <= 1'b0;
      end else begin
         r_full <= w_full_nxt;

         if (w_wr_fire) begin
            r_wcnt <= r_wcnt + 6'd1;       // wraps 63 -> 0 naturally
            if (w_wr_done) begin
               r_wb <= ~r_wb;
            end
         end

         if (w_rd_fire) begin
            r_rcnt <= r_rcnt + 6'd1;
            if (w_rd_done) begin
               r_rb <= ~r_rb;
            end
         end

         // Sideband registers track the RAM's registered read port: they
         // load with the read and otherwise hold alongside the RAM output.
         if (w_rd_fire) begin
            r_out_valid <= 1'b1;
            r_out_zz    <= r_rcnt;
            r_out_last  <= (r_rcnt == 6'd63);
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_zig_zag_block_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_zig_zag_block_sequencer
//
// Self-checking bench. The reference model tracks only the total number of
// coefficients accepted and read since reset; bank, index, fullness and
// zig-zag address all follow arithmetically from those two counts. The
// zig-zag order is generated by walking anti-diagonals.
// -----------------------------------------------------------------------------
module tb_zig_zag_block_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       wr_en;
   logic [6:0] wr_addr;
   logic       rd_en;
   logic [6:0] rd_addr;
   logic       out_valid;
   logic [5:0] out_zz_index;
   logic       out_last;
   logic [1:0] blocks_full;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   zig_zag_block_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_zz_index (out_zz_index),
      .out_last     (out_last),
      .blocks_full  (blocks_full)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   int m_zz_tab [64];
   int m_nwr = 0;        // coefficients accepted since reset
   int m_nrd = 0;        // RAM reads issued since reset
   bit m_ov = 1'b0;
   int m_zz = 0;
   bit m_last = 1'b0;

   initial begin
      int idx;
      int rlo;
      int rhi;
      idx = 0;
      for (int s = 0; s < 15; s++) begin
         rlo = (s > 7) ? s - 7 : 0;
         rhi = (s < 7) ? s : 7;
         if (s % 2 == 1) begin
            for (int r = rlo; r <= rhi; r++) begin
               m_zz_tab[idx] = r * 8 + (s - r);
               idx++;
            end
         end else begin
            for (int r = rhi; r >= rlo; r--) begin
               m_zz_tab[idx] = r * 8 + (s - r);
               idx++;
            end
         end
      end
   end

   function automatic int m_fullcnt(input int nwr, input int nrd);
      return (nwr / 64) - (nrd / 64);
   endfunction

   always @(posedge clock or posedge reset) begin
      bit rdy;
      bit fire;
      if (reset) begin
         m_nwr  = 0;
         m_nrd  = 0;
         m_ov   = 1'b0;
         m_zz   = 0;
         m_last = 1'b0;
      end else begin
         rdy  = m_fullcnt(m_nwr, m_nrd) < 2;
         fire = (m_fullcnt(m_nwr, m_nrd) > 0) && (!m_ov || out_ready);
         if (in_valid && rdy) m_nwr = m_nwr + 1;
         if (fire) begin
            m_ov   = 1'b1;
            m_zz   = m_nrd % 64;
            m_last = ((m_nrd % 64) == 63);
            m_nrd  = m_nrd + 1;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      int  fc;
      bit  e_rdy;
      bit  e_fire;
      if (chk_en) begin
         fc     = m_fullcnt(m_nwr, m_nrd);
         e_rdy  = fc < 2;
         e_fire = (fc > 0) && (!m_ov || out_ready);
         chk("in_ready",     {31'd0, in_ready},  {31'd0, e_rdy});
         chk("wr_en",        {31'd0, wr_en},     {31'd0, in_valid && e_rdy});
         chk("wr_addr",      {25'd0, wr_addr},   ((m_nwr / 64) % 2) * 64 + (m_nwr % 64));
         chk("rd_en",        {31'd0, rd_en},     {31'd0, e_fire});
         chk("rd_addr",      {25'd0, rd_addr},   ((m_nrd / 64) % 2) * 64 + m_zz_tab[m_nrd % 64]);
         chk("out_valid",    {31'd0, out_valid}, {31'd0, m_ov});
         chk("out_zz_index", {26'd0, out_zz_index}, m_zz);
         chk("out_last",     {31'd0, out_last},  {31'd0, m_last});
         chk("blocks_full",  {30'd0, blocks_full}, fc);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic write_n(input int n);
      int cnt;
      int cyc;
      cnt = 0;
      cyc = 0;
      in_valid = 1'b1;
      while (cnt < n && cyc < 2000) begin
         @(negedge clock);
         if (wr_en) cnt++;
         @(posedge clock);
         #1;
         cyc++;
         if (cnt >= n) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (cnt < n) begin
         errors++;
         $display("FAIL write_timeout actual=%0d required=%0d", cnt, n);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset;
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      chk("rst_in_ready",    {31'd0, in_ready},     32'd1);
      chk("rst_rd_en",       {31'd0, rd_en},        32'd0);
      chk("rst_out_valid",   {31'd0, out_valid},    32'd0);
      chk("rst_out_zz",      {26'd0, out_zz_index}, 32'd0);
      chk("rst_out_last",    {31'd0, out_last},     32'd0);
      chk("rst_blocks_full", {30'd0, blocks_full},  32'd0);
      chk("rst_wr_addr",     {25'd0, wr_addr},      32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      // Pin the generated zig-zag table to known entries.
      chk("zz_tab_2",  m_zz_tab[2],  32'o10);
      chk("zz_tab_17", m_zz_tab[17], 32'o23);
      chk("zz_tab_61", m_zz_tab[61], 32'o67);
      chk("zz_tab_63", m_zz_tab[63], 32'o77);

      // Reset state
      chk("init_in_ready",    {31'd0, in_ready},    32'd1);
      chk("init_blocks_full", {30'd0, blocks_full}, 32'd0);
      chk("init_out_valid",   {31'd0, out_valid},   32'd0);

      // One block, out_ready high: read issued the cycle after the last write.
      out_ready = 1'b1;
      write_n(64);
      chk("lat_rd_en",     {31'd0, rd_en},     32'd1);
      chk("lat_rd_addr",   {25'd0, rd_addr},   32'd0);
      chk("lat_out_valid", {31'd0, out_valid}, 32'd0);
      idle(1);
      chk("lat_out_valid1", {31'd0, out_valid},    32'd1);
      chk("lat_out_zz0",    {26'd0, out_zz_index}, 32'd0);
      chk("lat_rd_addr1",   {25'd0, rd_addr},      32'o01);
      idle(80);

      // Two blocks with downstream stalled, then drain.
      out_ready = 1'b0;
      write_n(128);
      chk("full2_in_ready",    {31'd0, in_ready},    32'd0);
      chk("full2_blocks_full", {30'd0, blocks_full}, 32'd2);
      in_valid = 1'b1;
      idle(5);
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(140);
      chk("drain_blocks_full", {30'd0, blocks_full}, 32'd0);

      // Continuous streaming.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      idle(300);
      in_valid = 1'b0;
      idle(140);

      // Toggling out_ready during drain.
      out_ready = 1'b0;
      write_n(64);
      for (int i = 0; i < 200; i++) begin
         @(posedge clock);
         #1;
         out_ready = ~out_ready;
      end
      out_ready = 1'b1;
      idle(10);

      // Reset after a partial block write.
      write_n(30);
      pulse_reset();
      chk("post_rst_wr_addr", {25'd0, wr_addr}, 32'd0);

      // Reset mid-drain.
      write_n(64);
      idle(20);
      pulse_reset();
      write_n(64);
      chk("bank0_rd_en",   {31'd0, rd_en},   32'd1);
      chk("bank0_rd_addr", {25'd0, rd_addr}, 32'd0);
      idle(80);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/zig_zag_block_sequencer.md
ZIG_ZAG_BLOCK_SEQUENCER -- requirements
Module: zig_zag_block_sequencer

Interface
REQ-001 The block SHALL have no parameters; the block size is fixed at 64 coefficients (8x8) and there are 2 banks.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents a row-major coefficient this cycle.
REQ-005 in_ready  output  1  block accepts a coefficient this cycle; combinational.
REQ-006 wr_en  output  1  write strobe to the external 128-entry coefficient RAM; combinational, equals in_valid && in_ready.
REQ-007 wr_addr  output  7  {write bank, 6-bit row-major index}; combinational.
REQ-008 rd_en  output  1  read strobe to the RAM's registered read port (1-cycle latency, output held while rd_en low); combinational.
REQ-009 rd_addr  output  7  {read bank, row-major index of the current zig-zag position}; combinational.
REQ-010 out_valid  output  1  RAM read data plus out_zz_index/out_last are valid; registered.
REQ-011 out_ready  input  1  downstream consumes the output this cycle.
REQ-012 out_zz_index  output  6  zig-zag position (0..63) of the current output; registered.
REQ-013 out_last  output  1  high with the output word at zig-zag position 63; registered.
REQ-014 blocks_full  output  2  count of banks fully written and not yet fully read (0..2); registered state.

Function
REQ-015 Per-bank state SHALL be a full flag; wb/rb = write/read bank pointers; wcnt/rcnt = 6-bit write/read counters.
REQ-016 in_ready SHALL equal !full[wb].
REQ-017 On accept (in_valid && in_ready): wr_addr = {wb, wcnt}; wcnt increments; at wcnt==63 wcnt wraps to 0, full[wb] sets and wb toggles at the same edge.
REQ-018 rd_fire SHALL equal full[rb] && (!out_valid || out_ready); rd_en = rd_fire.
REQ-019 rd_addr SHALL be {rb, row-major index of zig-zag position rcnt}, using the standard JPEG zig-zag table (e.g. rcnt 17 -> row 2, col 3 -> 6'o23; rcnt 63 -> 6'o77).
REQ-020 On rd_fire: rcnt increments; at rcnt==63 rcnt wraps to 0, full[rb] clears and rb toggles at the same edge.
REQ-021 out_valid SHALL load 1 on rd_fire, else clear when out_ready, else hold; out_zz_index <= rcnt and out_last <= (rcnt==63) on rd_fire only, otherwise held.
REQ-022 Latency: if the 64th write is accepted at edge N, rd_en SHALL be high during the cycle after N and out_valid SHALL rise at edge N+1, with out_zz_index 0.
REQ-023 Throughput: with out_ready held high, one output per cycle, 64 consecutive cycles per block, no bubbles between back-to-back full banks.
REQ-024 Backpressure: with out_ready low and out_valid high, rd_en SHALL be low and all output registers SHALL hold.
REQ-025 Both banks full: in_ready low until the read bank's rcnt==63 fire edge; in_ready high the following cycle.
REQ-026 Simultaneous write completion on one bank and read completion on the other SHALL both take effect; blocks_full unchanged (+1 -1).
REQ-027 A write and a read SHALL never target the same bank in the same cycle (guaranteed by the full flags).
REQ-028 in_valid with in_ready low SHALL cause no state change and wr_en low.

Reset
REQ-029 Reset SHALL clear full[1:0], wb, rb, wcnt, rcnt, out_valid, out_zz_index, out_last to 0; hence in_ready=1, rd_en=0, blocks_full=0.
REQ-030 Reset mid-block SHALL discard partially written and partially read blocks; the first accept after reset writes address 7'd0.

Verification
REQ-031 64 writes, out_ready=1 -> wr_addr 0..63; rd_addr sequence 00,01,10,20,11,02,03,...,67,76,77 (octal); out_zz_index 0..63; out_last only at 63.
REQ-032 128 writes, out_ready=0 -> in_ready low after 128th accept, blocks_full=2; raise out_ready -> 128 outputs, second block rd_addr bank bit=1.
REQ-033 Continuous in_valid, out_ready=1 -> steady state in_ready never drops, outputs gapless across blocks.
REQ-034 out_ready toggling 1/0 each cycle during drain -> out_zz_index strictly sequential, no skip or duplicate, rd_en only when slot free.
REQ-035 Reset asserted after 30 writes and mid-drain -> all outputs at reset values immediately; next block writes from 7'd0 and reads bank 0.
